// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, reads instruction memory, buffers words in a DEPTH-entry prefetch FIFO for decode.
// Latency 1 cycle from fetch edge to out_*; out_ready low holds the head and stalls fetch once the FIFO is full.
// Optional HALT_DETECT_EN: opcode 7'h7F stops fetching until redirect or reset.
module fetch_queue #(
  parameter int ADDR_W   = 7,
  parameter int INSTR_W  = 15,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [ADDR_W-1:0]  im_address,
  input  logic [INSTR_W-1:0] im_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6:0]         out_opcode,
  output logic [7:0]         out_literal,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]  pc;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [ADDR_W-1:0]  pc_mem   [DEPTH];
  logic [INSTR_W-1:0] word_mem [DEPTH];
  logic               push, pop;

  // Explicit wrap so non-power-of-two depths still cycle mod DEPTH.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign im_address = pc;
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign push       = run & ~redirect & ~halted & ((count < CNT_W'(DEPTH)) | pop);

  assign out_pc      = out_valid ? pc_mem[rd_ptr] : '0;
  assign out_opcode  = out_valid ? word_mem[rd_ptr][INSTR_W-1:INSTR_W-7] : '0;
  assign out_literal = out_valid ? word_mem[rd_ptr][7:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= ADDR_W'(RESET_PC);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        word_mem[i] <= '0;
      end
    end else if (redirect) begin
      // A same-cycle pop counts as accepted; everything else is discarded.
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= pc;
        word_mem[wr_ptr] <= im_data;
        wr_ptr           <= next_ptr(wr_ptr);
        pc               <= pc + ADDR_W'(1);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef HALT_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      halted <= 1'b0;
    else if (redirect)
      halted <= 1'b0;
    else if (push && (im_data[INSTR_W-1:INSTR_W-7] == 7'h7F))
      halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [6:0]  im_address;
  logic [14:0] im_data;
  logic        redirect;
  logic [6:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_opcode;
  logic [7:0]  out_literal;
  logic [6:0]  out_pc;
  logic        halted;

  logic [14:0] mem [128];
  assign im_data = mem[im_address];

  fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .run(run), .im_address(im_address), .im_data(im_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_opcode(out_opcode), .out_literal(out_literal),
    .out_pc(out_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  localparam int DEPTH = 2;

  // Reference model: queue of {fetch pc, word}
  typedef logic [21:0] ent_t;
  ent_t       mq[$];
  logic [6:0] m_pc;
  logic       m_halted;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc     = 7'd0;
    m_halted = 1'b0;
  endtask

  task automatic check_outputs();
    logic [21:0] h;
    h = (mq.size() != 0) ? mq[0] : 22'd0;
    check("out_valid",   32'(out_valid),   32'(mq.size() != 0));
    check("out_pc",      32'(out_pc),      32'(h[21:15]));
    check("out_opcode",  32'(out_opcode),  32'(h[14:8]));
    check("out_literal", 32'(out_literal), 32'(h[7:0]));
    check("im_address",  32'(im_address),  32'(m_pc));
    check("halted",      32'(halted),      32'(m_halted));
  endtask

  // One clock: check outputs, drive inputs, advance the model, take the edge.
  task automatic step(input logic r, input logic rdy, input logic rd, input logic [6:0] rpc);
    logic pop, push;
    logic [14:0] w;
    @(negedge clk);
    cyc++;
    check_outputs();
    run = r; out_ready = rdy; redirect = rd; redirect_pc = rpc;
    pop = (mq.size() != 0) && rdy;
    if (rd) begin
      mq.delete();
      m_pc     = rpc;
      m_halted = 1'b0;
    end else begin
      push = r && !m_halted && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (push) begin
        w = mem[m_pc];
        mq.push_back({m_pc, w});
`ifdef HALT_DETECT_EN
        if (w[14:8] == 7'h7F) m_halted = 1'b1;
`endif
        m_pc = m_pc + 7'd1;
      end
    end
    @(posedge clk);
  endtask

  task automatic steps(input int n, input logic r, input logic rdy);
    for (int i = 0; i < n; i++) step(r, rdy, 1'b0, 7'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = {7'(i), 8'(i + 1)};
    mem[3] = 15'h7F00;
    rst_n = 1'b0; run = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming from reset
    steps(12, 1'b1, 1'b1);
    // Stall from pc=0: fills to DEPTH, then releases
    step(1'b1, 1'b1, 1'b1, 7'd0);
    steps(5, 1'b1, 1'b0);
    steps(6, 1'b1, 1'b1);
    // Redirect with a full queue
    step(1'b1, 1'b1, 1'b1, 7'd20);
    steps(3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 7'd100);
    steps(4, 1'b1, 1'b1);
    // PC wrap-around
    step(1'b1, 1'b1, 1'b1, 7'd126);
    steps(6, 1'b1, 1'b1);
    // run=0 drains, then resumes at the held pc
    steps(3, 1'b1, 1'b0);
    steps(3, 1'b0, 1'b1);
    steps(3, 1'b1, 1'b1);
    // HALT word at address 3 (meaningful only with HALT_DETECT_EN)
    step(1'b1, 1'b1, 1'b1, 7'd0);
    steps(8, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 7'd10);
    steps(5, 1'b1, 1'b1);

    // Asynchronous reset mid-operation
    steps(2, 1'b1, 1'b0);
    @(negedge clk);
    run = 1'b0; out_ready = 1'b0; redirect = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #2 rst_n = 1'b1;

    for (int i = 0; i < 128; i++) begin
      mem[i] = 15'($urandom);
      if ($urandom_range(0, 7) == 0) mem[i][14:8] = 7'h7F;
    end
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), 7'($urandom));
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
